led_share_arbiter: RTL and testbench



---
 rtl/led_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_led_share_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_share_arbiter.sv
// Round-robin time-slicer that shares the active-low board LEDs between NUM_REQ pattern sources.
// Optional LED_GAP_ID_EN: show the just-finished owner's index (active-low) on the LEDs during GAP.
module led_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int LED_W       = 4,
   parameter int SLOT_CYCLES = 50000000,
   parameter int GAP_CYCLES  = 5000000,
   parameter int CNT_W       = 26
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*LED_W-1:0]   pattern,
   input  logic                       lock,
   output logic [NUM_REQ-1:0]         grant,
   output logic [LED_W-1:0]           led_out,
   output logic                       slot_start,
   output logic                       busy,
   output logic [1:0]                 dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] SLOT_LD = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
   localparam bit NO_GAP = (GAP_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [LED_W-1:0]   r_led;
   logic               r_slot_start;
   logic               r_busy;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_any;
   logic [IDX_W-1:0]   w_win;
   logic [IDX_W-1:0]   w_next_ptr;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [LED_W-1:0]   w_pat_win;
   logic [LED_W-1:0]   w_pat_own;
   logic               w_own_req;
   logic [LED_W-1:0]   w_gap_led;
   logic               w_slot_end;
   logic               w_gap_end;
   logic               w_arb;
   logic               w_do_start;
   logic               w_do_idle;
   logic               w_do_gap;

   // Rotating priority: first set req at or above r_rr_ptr, wrapping around.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any && req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_any = 1'b1;
            w_win = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign w_next_ptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);
   assign w_win_oh   = NUM_REQ'(1) << w_win;

   always_comb begin
      w_pat_win = '0;
      w_pat_own = '0;
      w_own_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == w_win) begin
            w_pat_win = pattern[i*LED_W +: LED_W];
         end
         if (IDX_W'(i) == r_owner) begin
            w_pat_own = pattern[i*LED_W +: LED_W];
            w_own_req = req[i];
         end
      end
   end

`ifdef LED_GAP_ID_EN
   assign w_gap_led = ~(LED_W'(r_owner));
`else
   assign w_gap_led = '1;
`endif

   // A dropped owner request ends the slot regardless of lock.
   always_comb begin
      w_slot_end = (r_state == ST_SHOW) && (!w_own_req || ((r_cnt == '0) && !lock));
      w_gap_end  = (r_state == ST_GAP) && (r_cnt == '0);
      w_arb      = (r_state == ST_IDLE) || w_gap_end || (w_slot_end && NO_GAP);
      w_do_start = w_arb && w_any;
      w_do_idle  = w_arb && !w_any;
      w_do_gap   = w_slot_end && !NO_GAP;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_led        <= '1;
         r_slot_start <= 1'b0;
         r_busy       <= 1'b0;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_cnt        <= '0;
      end else begin
         r_slot_start <= 1'b0;
         if (w_do_start) begin
            r_state      <= ST_SHOW;
            r_busy       <= 1'b1;
            r_grant      <= w_win_oh;
            r_owner      <= w_win;
            r_rr_ptr     <= w_next_ptr;
            r_cnt        <= SLOT_LD;
            r_slot_start <= 1'b1;
            r_led        <= ~w_pat_win;
         end else if (w_do_idle) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_grant <= '0;
            r_led   <= '1;
            r_cnt   <= '0;
         end else if (w_do_gap) begin
            r_state <= ST_GAP;
            r_busy  <= 1'b1;
            r_grant <= '0;
            r_led   <= w_gap_led;
            r_cnt   <= GAP_LD;
         end else if (r_state == ST_SHOW) begin
            r_led <= ~w_pat_own;
            r_cnt <= (r_cnt == '0) ? SLOT_LD : r_cnt - 1'b1;
         end else if (r_state == ST_GAP) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign grant      = r_grant;
   assign led_out    = r_led;
   assign slot_start = r_slot_start;
   assign busy       = r_busy;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: table of input phases with per-cycle expected outputs, checked
// through an expected queue; one instance with a 2-cycle gap, one with no gap.
module tb_led_share_arbiter;

   localparam logic [15:0] PAT  = 16'hC635;
   localparam logic [15:0] PAT2 = 16'hC639;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req, req0;
   logic [15:0] pattern, pattern0;
   logic        lock, lock0;
   logic [3:0]  grant, grant0;
   logic [3:0]  led_out, led_out0;
   logic        slot_start, slot_start0;
   logic        busy, busy0;
   logic [1:0]  dbg_state, dbg_state0;

   int n_assert;
   int n_fail;

   logic [18:0] exp_q[$];

   typedef struct {
      int         sel;
      logic [3:0] rq;
      logic       lk;
      logic [15:0] pt;
      int         n;
      logic [3:0] g;
      logic [3:0] l;
      logic       b;
      logic       ss;
   } row_t;

   row_t rows[$];

   led_share_arbiter #(.NUM_REQ(4), .LED_W(4), .SLOT_CYCLES(8), .GAP_CYCLES(2), .CNT_W(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req), .pattern(pattern), .lock(lock),
      .grant(grant), .led_out(led_out), .slot_start(slot_start), .busy(busy), .dbg_state(dbg_state)
   );

   led_share_arbiter #(.NUM_REQ(4), .LED_W(4), .SLOT_CYCLES(8), .GAP_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .req(req0), .pattern(pattern0), .lock(lock0),
      .grant(grant0), .led_out(led_out0), .slot_start(slot_start0), .busy(busy0), .dbg_state(dbg_state0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] gl(input int idx);
`ifdef LED_GAP_ID_EN
      return ~(4'(idx));
`else
      return 4'hF;
`endif
   endfunction

   function automatic row_t mk(input int sel, input logic [3:0] rq, input logic lk, input logic [15:0] pt,
                               input int n, input logic [3:0] g, input logic [3:0] l, input logic b,
                               input logic ss);
      row_t r;
      r.sel = sel; r.rq = rq; r.lk = lk; r.pt = pt; r.n = n;
      r.g = g; r.l = l; r.b = b; r.ss = ss;
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic apply_row(input int id);
      row_t r;
      r = rows[id];
      for (int c = 0; c < r.n; c++) begin
         @(negedge clk);
         if (r.sel == 0) begin
            req = r.rq; lock = r.lk; pattern = r.pt;
            req0 = '0; lock0 = 1'b0; pattern0 = r.pt;
         end else begin
            req0 = r.rq; lock0 = r.lk; pattern0 = r.pt;
            req = '0; lock = 1'b0; pattern = r.pt;
         end
         exp_q.push_back({8'(id), (r.sel != 0), r.g, r.l, (r.ss && (c == 0)), r.b});
      end
   endtask

   // Outputs after each edge reflect the inputs driven in the preceding low phase.
   always @(posedge clk) begin
      logic [18:0] e;
      logic [9:0]  got;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = e[10] ? {grant0, led_out0, slot_start0, busy0} : {grant, led_out, slot_start, busy};
         n_assert++;
         if (got !== e[9:0]) begin
            n_fail++;
            $display("FAIL row%0d dut%0d: got grant=%b led=%h ss=%b busy=%b, expected grant=%b led=%h ss=%b busy=%b",
                     e[18:11], e[10], got[9:6], got[5:2], got[1], got[0], e[9:6], e[5:2], e[1], e[0]);
         end
      end
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      req = '0; req0 = '0; lock = 1'b0; lock0 = 1'b0; pattern = PAT; pattern0 = PAT;

      rows.push_back(mk(0, 4'b0000, 0, PAT,  20, 4'b0000, 4'hF,  0, 0));
      rows.push_back(mk(0, 4'b1010, 0, PAT,   8, 4'b0010, 4'hC,  1, 1));
      rows.push_back(mk(0, 4'b1010, 0, PAT,   2, 4'b0000, gl(1), 1, 0));
      rows.push_back(mk(0, 4'b1010, 0, PAT,   8, 4'b1000, 4'h3,  1, 1));
      rows.push_back(mk(0, 4'b1010, 0, PAT,   2, 4'b0000, gl(3), 1, 0));
      rows.push_back(mk(0, 4'b0000, 1, PAT,   3, 4'b0000, 4'hF,  0, 0));
      rows.push_back(mk(0, 4'b0001, 1, PAT,  10, 4'b0001, 4'hA,  1, 1));
      rows.push_back(mk(0, 4'b0001, 1, PAT2, 14, 4'b0001, 4'h6,  1, 0));
      rows.push_back(mk(0, 4'b0001, 0, PAT2,  2, 4'b0000, gl(0), 1, 0));
      rows.push_back(mk(0, 4'b0001, 0, PAT2,  8, 4'b0001, 4'h6,  1, 1));
      rows.push_back(mk(0, 4'b0000, 0, PAT,   2, 4'b0000, gl(0), 1, 0));
      rows.push_back(mk(0, 4'b0000, 0, PAT,   2, 4'b0000, 4'hF,  0, 0));
      rows.push_back(mk(0, 4'b0100, 0, PAT,   3, 4'b0100, 4'h9,  1, 1));
      rows.push_back(mk(0, 4'b1011, 0, PAT,   2, 4'b0000, gl(2), 1, 0));
      rows.push_back(mk(0, 4'b1011, 0, PAT,   8, 4'b1000, 4'h3,  1, 1));
      rows.push_back(mk(0, 4'b1011, 0, PAT,   2, 4'b0000, gl(3), 1, 0));
      rows.push_back(mk(0, 4'b1011, 0, PAT,   3, 4'b0001, 4'hA,  1, 1));
      rows.push_back(mk(0, 4'b1111, 0, PAT,   8, 4'b0001, 4'hA,  1, 1));
      rows.push_back(mk(0, 4'b1111, 0, PAT,   2, 4'b0000, gl(0), 1, 0));
      rows.push_back(mk(0, 4'b1111, 0, PAT,   1, 4'b0010, 4'hC,  1, 1));
      rows.push_back(mk(0, 4'b0000, 0, PAT,   2, 4'b0000, gl(1), 1, 0));
      rows.push_back(mk(0, 4'b0000, 0, PAT,   2, 4'b0000, 4'hF,  0, 0));
      rows.push_back(mk(1, 4'b0011, 0, PAT,   8, 4'b0001, 4'hA,  1, 1));
      rows.push_back(mk(1, 4'b0011, 0, PAT,   8, 4'b0010, 4'hC,  1, 1));
      rows.push_back(mk(1, 4'b0011, 0, PAT,   8, 4'b0001, 4'hA,  1, 1));
      rows.push_back(mk(1, 4'b0000, 0, PAT,   3, 4'b0000, 4'hF,  0, 0));

      @(negedge clk);
      @(negedge clk);
      check("reset_main", {grant, led_out, 3'b0, slot_start, busy, 1'b0, dbg_state},
            {4'b0000, 4'hF, 3'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      check("reset_nogap", {grant0, led_out0, 3'b0, slot_start0, busy0, 1'b0, dbg_state0},
            {4'b0000, 4'hF, 3'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      reset_n = 1'b1;

      for (int i = 0; i <= 16; i++) apply_row(i);

      // Asynchronous reset in the middle of a slot, then the pointer must restart at 0.
      @(negedge clk);
      #2;
      req = '0;
      reset_n = 1'b0;
      #1;
      check("midreset_out", {grant, led_out, 3'b0, slot_start, busy, 1'b0, dbg_state},
            {4'b0000, 4'hF, 3'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 17; i < rows.size(); i++) apply_row(i);

      @(posedge clk);
      #2;
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
